// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse initialisation sequencer.
// Contents: PS/2 command/response byte constants, sequencer state encoding,
// failure code encoding and packet framing constants.
package ps2_mouse_pkg;

  // Host-to-device commands
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_SET_RES  = 8'hE8;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Device-to-host responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] ID_MOUSE     = 8'h00;

  // Index of the final command (F4) in the configuration list
  localparam logic [2:0] LAST_IDX     = 3'd5;

  // Bit of packet byte 0 that is always set; used to find packet alignment
  localparam int unsigned PKT_SYNC_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_RETRY,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_NEXT,
    ST_RUN,
    ST_FAIL
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_RETRY    = 3'd1,
    FC_BAT_TMO  = 3'd2,
    FC_BAT_FAIL = 3'd3,
    FC_BAD_ID   = 3'd4
  } fail_code_e;

endpackage

// File: rtl/ps2_mouse_init_sequencer_framer.sv
// ps2_packet_framer: assembles 3-byte PS/2 mouse movement packets.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               framing enabled (mouse is streaming)
//   rx_valid/rx_byte received byte strobe and data
//   rx_err           receive error; drops any partial packet
//   status_o/x_o/y_o last complete packet, updated together
//   packet_valid_o   one-cycle pulse in the cycle the outputs update
module ps2_packet_framer
  import ps2_mouse_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  output logic [7:0] status_o,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       packet_valid_o
);

  logic [1:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic       commit_q, commit_d;
  logic [7:0] status_q, status_d, x_q, x_d, y_q, y_d;
  logic       pv_q, pv_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    commit_d  = 1'b0;
    status_d  = status_q;
    x_d       = x_q;
    y_d       = y_q;
    pv_d      = 1'b0;

    if (!en) begin
      pkt_cnt_d = 2'd0;
    end else if (rx_err) begin
      // An error also masks a coincident rx_valid
      pkt_cnt_d = 2'd0;
    end else if (rx_valid) begin
      unique case (pkt_cnt_q)
        2'd0: begin
          // Bytes without the sync bit cannot start a packet; drop them
          if (rx_byte[PKT_SYNC_BIT]) begin
            b0_d      = rx_byte;
            pkt_cnt_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d      = rx_byte;
          pkt_cnt_d = 2'd2;
        end
        default: begin
          b2_d      = rx_byte;
          pkt_cnt_d = 2'd0;
          commit_d  = 1'b1;
        end
      endcase
    end

    // Complete packet moves from the holding registers to the outputs as a unit
    if (commit_q) begin
      status_d = b0_q;
      x_d      = b1_q;
      y_d      = b2_q;
      pv_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= 2'd0;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
      b2_q      <= 8'h00;
      commit_q  <= 1'b0;
      status_q  <= 8'h00;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      pv_q      <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      commit_q  <= commit_d;
      status_q  <= status_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pv_q      <= pv_d;
    end
  end

  assign status_o       = status_q;
  assign x_o            = x_q;
  assign y_o            = y_q;
  assign packet_valid_o = pv_q;

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// ps2_mouse_init_sequencer: brings a PS/2 mouse from power-up to streaming
// mode (FF, F3 <rate>, E8 <res>, F4), checking every acknowledge with
// bounded retries and timeouts, then frames movement packets.
// Ports:
//   Clock_100MHz, Clear_n        clock, asynchronous active-low reset
//   start                        starts/restarts initialisation (IDLE/RUN/FAIL)
//   tx_req/tx_byte/tx_busy       byte handshake to the bit-level transmitter
//   tx_done/tx_err               transmitter completion / failure pulses
//   rx_valid/rx_byte/rx_err      byte handshake from the bit-level receiver
//   init_done/init_fail          configuration status levels
//   fail_code                    reason for init_fail
//   Status_out/X_Direction/Y_Direction/packet_valid  framed movement packet
module ps2_mouse_init_sequencer
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CYC = 2_500_000,
  parameter int unsigned BAT_TIMEOUT_CYC = 100_000_000,
  parameter int unsigned MAX_RETRY       = 3,
  parameter logic [7:0]  SAMPLE_RATE     = 8'd100,
  parameter logic [7:0]  RESOLUTION      = 8'd2,
  parameter int unsigned TMR_W           = 27
) (
  input  logic       Clock_100MHz,
  input  logic       Clear_n,
  input  logic       start,
  output logic       tx_req,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  output logic       init_done,
  output logic       init_fail,
  output logic [2:0] fail_code,
  output logic [7:0] Status_out,
  output logic [7:0] X_Direction,
  output logic [7:0] Y_Direction,
  output logic       packet_valid
);

  localparam int unsigned RC_W = $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] BAT_LOAD = TMR_W'(BAT_TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  function automatic logic [7:0] cmd_byte(input logic [2:0] i);
    unique case (i)
      3'd0:    cmd_byte = CMD_RESET;
      3'd1:    cmd_byte = CMD_SET_RATE;
      3'd2:    cmd_byte = SAMPLE_RATE;
      3'd3:    cmd_byte = CMD_SET_RES;
      3'd4:    cmd_byte = RESOLUTION;
      default: cmd_byte = CMD_ENABLE;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [RC_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              tx_req_q, tx_req_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              init_done_q, init_done_d;
  logic              init_fail_q, init_fail_d;
  fail_code_e        fail_code_q, fail_code_d;

  // A byte flagged with rx_err is never acted on as data
  logic rx_ok;
  assign rx_ok = rx_valid & ~rx_err;

  // A timer value of 1 on entry to a check means the window has elapsed
  logic tmr_expired;
  assign tmr_expired = (timer_q <= TMR_ONE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    tx_req_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    init_done_d = init_done_q;
    init_fail_d = init_fail_q;
    fail_code_d = fail_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d       = 3'd0;
          retry_cnt_d = '0;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_req_d    = 1'b1;
          tx_byte_d   = cmd_byte(idx_q);
          retry_cnt_d = retry_cnt_q + RC_W'(1);
          state_d     = ST_WAIT_TX;
        end
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          timer_d = ACK_LOAD;
          state_d = ST_WAIT_ACK;
        end else if (tx_err) begin
          state_d = ST_RETRY;
        end
      end

      ST_WAIT_ACK: begin
        if (rx_err) begin
          state_d = ST_RETRY;
        end else if (rx_valid) begin
          if (rx_byte == RSP_ACK) begin
            if (idx_q == 3'd0) begin
              // Reset command: the device follows its ACK with BAT result and ID
              timer_d = BAT_LOAD;
              state_d = ST_WAIT_BAT;
            end else begin
              state_d = ST_NEXT;
            end
          end else begin
            state_d = ST_RETRY;
          end
        end else if (tmr_expired) begin
          state_d = ST_RETRY;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      ST_RETRY: begin
        if (retry_cnt_q == RC_MAX) begin
          init_fail_d = 1'b1;
          fail_code_d = FC_RETRY;
          state_d     = ST_FAIL;
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_WAIT_BAT: begin
        if (rx_ok && (rx_byte == RSP_BAT_OK)) begin
          timer_d = BAT_LOAD;
          state_d = ST_WAIT_ID;
        end else if (rx_ok && (rx_byte == RSP_ERROR)) begin
          init_fail_d = 1'b1;
          fail_code_d = FC_BAT_FAIL;
          state_d     = ST_FAIL;
        end else if (tmr_expired) begin
          init_fail_d = 1'b1;
          fail_code_d = FC_BAT_TMO;
          state_d     = ST_FAIL;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      ST_WAIT_ID: begin
        if (rx_ok) begin
          if (rx_byte == ID_MOUSE) begin
            state_d = ST_NEXT;
          end else begin
            init_fail_d = 1'b1;
            fail_code_d = FC_BAD_ID;
            state_d     = ST_FAIL;
          end
        end else if (tmr_expired) begin
          init_fail_d = 1'b1;
          fail_code_d = FC_BAT_TMO;
          state_d     = ST_FAIL;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      ST_NEXT: begin
        retry_cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          init_done_d = 1'b1;
          state_d     = ST_RUN;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_SEND;
        end
      end

      ST_RUN, ST_FAIL: begin
        if (start) begin
          init_done_d = 1'b0;
          init_fail_d = 1'b0;
          fail_code_d = FC_NONE;
          idx_d       = 3'd0;
          retry_cnt_d = '0;
          state_d     = ST_SEND;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      retry_cnt_q <= '0;
      timer_q     <= '0;
      tx_req_q    <= 1'b0;
      tx_byte_q   <= 8'h00;
      init_done_q <= 1'b0;
      init_fail_q <= 1'b0;
      fail_code_q <= FC_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      tx_req_q    <= tx_req_d;
      tx_byte_q   <= tx_byte_d;
      init_done_q <= init_done_d;
      init_fail_q <= init_fail_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_byte   = tx_byte_q;
  assign init_done = init_done_q;
  assign init_fail = init_fail_q;
  assign fail_code = fail_code_q;

  // Framing only runs once the mouse is configured; pkt_cnt is held clear otherwise
  ps2_packet_framer u_framer (
    .clk            (Clock_100MHz),
    .rst_n          (Clear_n),
    .en             (init_done_q),
    .rx_valid       (rx_valid),
    .rx_byte        (rx_byte),
    .rx_err         (rx_err),
    .status_o       (Status_out),
    .x_o            (X_Direction),
    .y_o            (Y_Direction),
    .packet_valid_o (packet_valid)
  );

endmodule
